// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode map, immediate formats
// and the positions of the fields this stage reads from the control bundle.
package decode_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Mem-read flag position inside the control-unit bundle.
    localparam int CTRL_MEM_READ_BIT = 0;
    localparam int CTRL_W_DEFAULT    = 16;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_regfile_bypass.sv
// Architectural register file with x0 hard-wired to zero and write-through
// bypass on both operand ports and on the debug port.
module regfile_bypass #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic [AW-1:0]   dbg_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] dbg_data_o
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    // Every entry clears on reset so a debug read during reset shows zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0)                ? '0      :
                        (wr_en && waddr_i == rs1_addr_i)  ? wdata_i :
                                                            mem_q[rs1_addr_i];

    assign rs2_data_o = (rs2_addr_i == '0)                ? '0      :
                        (wr_en && waddr_i == rs2_addr_i)  ? wdata_i :
                                                            mem_q[rs2_addr_i];

    assign dbg_data_o = (dbg_addr_i == '0)                ? '0      :
                        (wr_en && waddr_i == dbg_addr_i)  ? wdata_i :
                                                            mem_q[dbg_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode with ID/EX register: operand fetch, immediate generation,
// load-use stall detection and hold/flush/bubble control.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int CTRL_W   = CTRL_W_DEFAULT,
    parameter int LOAD_BIT = CTRL_MEM_READ_BIT,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr_if,
    input  logic [XLEN-1:0]   pc_if,
    input  logic              valid_if,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic              flush,
    input  logic              hold,
    input  logic              rf_we,
    input  logic [AW-1:0]     rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    input  logic [AW-1:0]     dbg_addr,
    output logic              stall,
    output logic              valid_id,
    output logic [XLEN-1:0]   pc_id,
    output logic [CTRL_W-1:0] ctrl_id,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [AW-1:0]     rs1_id,
    output logic [AW-1:0]     rs2_id,
    output logic [AW-1:0]     rd_id,
    output logic [XLEN-1:0]   imm_id,
    output logic [3:0]        func_id,
    output logic [XLEN-1:0]   dbg_data
);

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins);
        logic [31:0] imm;
        case (imm_fmt(ins[6:0]))
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return XLEN'($signed(imm));
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
    endfunction

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1_idx;
    logic [AW-1:0]   rs2_idx;
    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;

    assign opcode  = instr_if[6:0];
    assign rs1_idx = AW'(instr_if[19:15]);
    assign rs2_idx = AW'(instr_if[24:20]);
    assign rd_idx  = AW'(instr_if[11:7]);

    regfile_bypass #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i      (clock),
        .rst_i      (reset),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .rs1_addr_i (rs1_idx),
        .rs2_addr_i (rs2_idx),
        .dbg_addr_i (dbg_addr),
        .rs1_data_o (rf_rs1),
        .rs2_data_o (rf_rs2),
        .dbg_data_o (dbg_data)
    );

    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   pc_q,     pc_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d_q;
    logic [XLEN-1:0]   rs1d_q,   rs1d_d;
    logic [XLEN-1:0]   rs2d_q,   rs2d_d;
    logic [AW-1:0]     rs1_q,    rs1_d;
    logic [AW-1:0]     rs2_q,    rs2_d;
    logic [AW-1:0]     rd_q,     rd_d;
    logic [XLEN-1:0]   imm_q,    imm_d;
    logic [3:0]        func_q,   func_d;

    // A load in ID/EX whose destination is a source of the instruction in
    // IF/ID; a flush kills the consumer, so there is nothing to wait for.
    assign stall = valid_if && valid_q && ctrl_q[LOAD_BIT] && (rd_q != '0) &&
                   ((uses_rs1(opcode) && rs1_idx == rd_q) ||
                    (uses_rs2(opcode) && rs2_idx == rd_q)) &&
                   !flush;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        ctrl_d_q = ctrl_q;
        rs1d_d   = rs1d_q;
        rs2d_d   = rs2d_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        func_d   = func_q;
        if (hold) begin
            // ID/EX frozen; the defaults above already keep every field.
        end else if (flush || stall || !valid_if) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            ctrl_d_q = '0;
            rs1d_d   = '0;
            rs2d_d   = '0;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            imm_d    = '0;
            func_d   = '0;
        end else begin
            valid_d  = 1'b1;
            pc_d     = pc_if;
            ctrl_d_q = ctrl_d;
            rs1d_d   = rf_rs1;
            rs2d_d   = rf_rs2;
            rs1_d    = rs1_idx;
            rs2_d    = rs2_idx;
            rd_d     = rd_idx;
            imm_d    = gen_imm(instr_if);
            func_d   = {instr_if[30], instr_if[14:12]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            rs1d_q  <= '0;
            rs2d_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            func_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d_q;
            rs1d_q  <= rs1d_d;
            rs2d_q  <= rs2d_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            func_q  <= func_d;
        end
    end

    assign valid_id = valid_q;
    assign pc_id    = pc_q;
    assign ctrl_id  = ctrl_q;
    assign rs1_data = rs1d_q;
    assign rs2_data = rs2d_q;
    assign rs1_id   = rs1_q;
    assign rs2_id   = rs2_q;
    assign rd_id    = rd_q;
    assign imm_id   = imm_q;
    assign func_id  = func_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit/32-register instance checked via an
// expected-result queue, plus a 64-bit/16-register instance for width behaviour.
module tb_decode_stage;

    // Clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Narrow instance (XLEN=32, NREGS=32)
    logic [31:0] instr_if, pc_if, rf_wdata, pc_id, rs1_data, rs2_data, imm_id, dbg_data;
    logic        valid_if, flush, hold, rf_we, stall, valid_id;
    logic [15:0] ctrl_d, ctrl_id;
    logic [4:0]  rf_waddr, dbg_addr, rs1_id, rs2_id, rd_id;
    logic [3:0]  func_id;

    decode_stage #(.XLEN(32), .NREGS(32), .CTRL_W(16), .LOAD_BIT(0)) dut (
        .clock(clock), .reset(reset), .instr_if(instr_if), .pc_if(pc_if),
        .valid_if(valid_if), .ctrl_d(ctrl_d), .flush(flush), .hold(hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dbg_addr(dbg_addr),
        .stall(stall), .valid_id(valid_id), .pc_id(pc_id), .ctrl_id(ctrl_id),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_id(rd_id), .imm_id(imm_id), .func_id(func_id), .dbg_data(dbg_data)
    );

    // Wide instance (XLEN=64, NREGS=16)
    logic [31:0] instr_w;
    logic [63:0] pc_w, rf_wdata_w, pc_id_w, rs1_data_w, rs2_data_w, imm_id_w, dbg_data_w;
    logic        valid_w, flush_w, hold_w, rf_we_w, stall_w, valid_id_w;
    logic [15:0] ctrl_w, ctrl_id_w;
    logic [3:0]  rf_waddr_w, dbg_addr_w, rs1_id_w, rs2_id_w, rd_id_w;
    logic [3:0]  func_id_w;

    decode_stage #(.XLEN(64), .NREGS(16), .CTRL_W(16), .LOAD_BIT(0)) dut_w (
        .clock(clock), .reset(reset), .instr_if(instr_w), .pc_if(pc_w),
        .valid_if(valid_w), .ctrl_d(ctrl_w), .flush(flush_w), .hold(hold_w),
        .rf_we(rf_we_w), .rf_waddr(rf_waddr_w), .rf_wdata(rf_wdata_w), .dbg_addr(dbg_addr_w),
        .stall(stall_w), .valid_id(valid_id_w), .pc_id(pc_id_w), .ctrl_id(ctrl_id_w),
        .rs1_data(rs1_data_w), .rs2_data(rs2_data_w), .rs1_id(rs1_id_w), .rs2_id(rs2_id_w),
        .rd_id(rd_id_w), .imm_id(imm_id_w), .func_id(func_id_w), .dbg_data(dbg_data_w)
    );

    // Scoreboard
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  func;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   total = 0;
    int   bad   = 0;
    int   edge_no = 0;

    localparam logic [31:0] I_ADD_X1_X3 = 32'h000180B3;  // add x1,x3,x0
    localparam logic [31:0] I_LW_X7     = 32'h00012383;  // lw  x7,0(x2)
    localparam logic [31:0] I_ADD_X8_X7 = 32'h00138433;  // add x8,x7,x1
    localparam logic [31:0] I_LUI_X7    = 32'h800383B7;  // lui x7 (rs1 field = 7)
    localparam logic [31:0] I_ADDI_M1   = 32'hFFF00093;  // addi x1,x0,-1
    localparam logic [31:0] I_BEQ_M4    = 32'hFE000EE3;  // beq x0,x0,-4
    localparam logic [31:0] I_JAL_2K    = 32'h0010006F;  // jal x0,+2048
    localparam logic [15:0] C_ALU       = 16'h00A0;
    localparam logic [15:0] C_LOAD      = 16'h0001;

    function automatic exp_t mk_load(input logic [31:0] pc, input logic [15:0] ctrl,
                                     input logic [31:0] r1d, input logic [31:0] r2d,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] rd, input logic [31:0] imm,
                                     input logic [3:0] func);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.ctrl = ctrl; e.r1d = r1d; e.r2d = r2d;
        e.r1 = r1; e.r2 = r2; e.rd = rd; e.imm = imm; e.func = func;
        return e;
    endfunction

    function automatic exp_t mk_bubble();
        exp_t e;
        e = '0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input exp_t e);
        exp_q.push_back(e);
        last_e = e;
    endtask

    // Advance one edge and compare the ID/EX register against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        edge_no++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("valid_id@%0d", edge_no), valid_id, e.valid);
            check($sformatf("pc_id@%0d",    edge_no), pc_id,    e.pc);
            check($sformatf("ctrl_id@%0d",  edge_no), ctrl_id,  e.ctrl);
            check($sformatf("rs1_data@%0d", edge_no), rs1_data, e.r1d);
            check($sformatf("rs2_data@%0d", edge_no), rs2_data, e.r2d);
            check($sformatf("rs1_id@%0d",   edge_no), rs1_id,   e.r1);
            check($sformatf("rs2_id@%0d",   edge_no), rs2_id,   e.r2);
            check($sformatf("rd_id@%0d",    edge_no), rd_id,    e.rd);
            check($sformatf("imm_id@%0d",   edge_no), imm_id,   e.imm);
            check($sformatf("func_id@%0d",  edge_no), func_id,  e.func);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic v, input logic [15:0] ctrl);
        instr_if = instr;
        pc_if    = pc;
        valid_if = v;
        ctrl_d   = ctrl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(32'h0, 32'h0, 1'b0, 16'h0);
        flush = 0; hold = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0; dbg_addr = 0;
        instr_w = 0; pc_w = 0; valid_w = 0; ctrl_w = 0; flush_w = 0; hold_w = 0;
        rf_we_w = 0; rf_waddr_w = 0; rf_wdata_w = 0; dbg_addr_w = 0;

        // Power-on reset
        #1 reset = 1'b1;
        #2;
        check("reset_valid_id", valid_id, 0);
        check("reset_pc_id", pc_id, 0);
        check("reset_stall", stall, 0);
        check("reset_valid_id_w", valid_id_w, 0);
        @(negedge clock);
        reset = 1'b0;

        // Write-through: x3 written in the same cycle the add reads it
        rf_we = 1; rf_waddr = 3; rf_wdata = 32'h1234; dbg_addr = 3;
        drive(I_ADD_X1_X3, 32'h100, 1'b1, C_ALU);
        #1 check("dbg_bypass_x3", dbg_data, 32'h1234);
        push(mk_load(32'h100, C_ALU, 32'h1234, 0, 3, 0, 1, 0, 4'h0));
        tick();

        // Write to x0 is discarded; idle slot produces a bubble
        rf_waddr = 0; rf_wdata = 32'hFFFF; dbg_addr = 0;
        drive(32'h0, 32'h0, 1'b0, 16'h0);
        #1 check("dbg_x0_during_write", dbg_data, 0);
        push(mk_bubble());
        tick();
        rf_we = 0;
        #1 check("dbg_x0_after_write", dbg_data, 0);
        dbg_addr = 3;
        #1 check("dbg_x3_stored", dbg_data, 32'h1234);

        // lw x7 enters ID/EX (x1 <- 0x11 written alongside)
        rf_we = 1; rf_waddr = 1; rf_wdata = 32'h11;
        drive(I_LW_X7, 32'h104, 1'b1, C_LOAD);
        #1 check("no_stall_after_bubble", stall, 0);
        push(mk_load(32'h104, C_LOAD, 0, 0, 2, 0, 7, 0, 4'h2));
        tick();

        // add x8,x7,x1 behind the load: one stall cycle and a bubble
        rf_we = 0;
        drive(I_ADD_X8_X7, 32'h108, 1'b1, C_ALU);
        #1 check("load_use_stall", stall, 1);
        push(mk_bubble());
        tick();

        // Load data written back while the add retries; stall must be gone
        rf_we = 1; rf_waddr = 7; rf_wdata = 32'h777;
        #1 check("stall_one_cycle", stall, 0);
        push(mk_load(32'h108, C_ALU, 32'h777, 32'h11, 7, 1, 8, 0, 4'h0));
        tick();

        // lw x7 then lui x7: lui reads no register, so no stall
        rf_we = 0;
        drive(I_LW_X7, 32'h10C, 1'b1, C_LOAD);
        push(mk_load(32'h10C, C_LOAD, 0, 0, 2, 0, 7, 0, 4'h2));
        tick();
        drive(I_LUI_X7, 32'h110, 1'b1, C_ALU);
        #1 check("no_stall_lui", stall, 0);
        push(mk_load(32'h110, C_ALU, 32'h777, 0, 7, 0, 7, 32'h80038000, 4'h0));
        tick();

        // flush with hold: hold wins, ID/EX unchanged
        drive(I_ADDI_M1, 32'h114, 1'b1, C_ALU);
        flush = 1; hold = 1;
        push(last_e);
        tick();

        // flush alone: bubble
        hold = 0;
        push(mk_bubble());
        tick();
        flush = 0;

        // Immediates: I (-1), B (-4), J (+2048)
        drive(I_ADDI_M1, 32'h118, 1'b1, C_ALU);
        push(mk_load(32'h118, C_ALU, 0, 0, 0, 31, 1, 32'hFFFFFFFF, 4'h8));
        tick();
        drive(I_BEQ_M4, 32'h11C, 1'b1, C_ALU);
        push(mk_load(32'h11C, C_ALU, 0, 0, 0, 0, 29, 32'hFFFFFFFC, 4'h8));
        tick();
        rf_we = 1; rf_waddr = 5; rf_wdata = 32'hDEAD;
        drive(I_JAL_2K, 32'h120, 1'b1, C_ALU);
        push(mk_load(32'h120, C_ALU, 0, 32'h11, 0, 1, 0, 32'h00000800, 4'h0));
        tick();
        rf_we = 0; dbg_addr = 5;
        #1 check("dbg_x5_written", dbg_data, 32'hDEAD);

        // Load-use while held: stall stays up, ID/EX frozen, then bubble, then add
        drive(I_LW_X7, 32'h124, 1'b1, C_LOAD);
        push(mk_load(32'h124, C_LOAD, 0, 0, 2, 0, 7, 0, 4'h2));
        tick();
        drive(I_ADD_X8_X7, 32'h128, 1'b1, C_ALU);
        hold = 1;
        #1 check("stall_under_hold", stall, 1);
        push(last_e);
        tick();
        check("stall_under_hold_2", stall, 1);
        hold = 0;
        #1 check("stall_after_hold", stall, 1);
        push(mk_bubble());
        tick();
        check("stall_cleared", stall, 0);
        push(mk_load(32'h128, C_ALU, 32'h777, 32'h11, 7, 1, 8, 0, 4'h0));
        tick();

        // Asynchronous reset in the middle of a stall
        drive(I_LW_X7, 32'h12C, 1'b1, C_LOAD);
        push(mk_load(32'h12C, C_LOAD, 0, 0, 2, 0, 7, 0, 4'h2));
        tick();
        drive(I_ADD_X8_X7, 32'h130, 1'b1, C_ALU);
        #1 check("stall_before_reset", stall, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid_id", valid_id, 0);
        check("async_reset_stall", stall, 0);
        check("async_reset_pc_id", pc_id, 0);
        check("async_reset_ctrl_id", ctrl_id, 0);
        check("async_reset_rd_id", rd_id, 0);
        check("async_reset_dbg_x5", dbg_data, 0);
        #1 reset = 1'b0;
        push(mk_load(32'h130, C_ALU, 0, 0, 7, 1, 8, 0, 4'h0));
        tick();

        // Wide instance: 64-bit data, 4-bit register indices
        drive(32'h0, 32'h0, 1'b0, 16'h0);
        rf_we_w = 1; rf_waddr_w = 1; rf_wdata_w = 64'hCAFE_0000_0000_0001;
        instr_w = 32'h00088133;  // add x2,x17,x0
        pc_w = 64'h1_0000_0000; valid_w = 1; ctrl_w = C_ALU;
        tick();
        check("w_valid_id", valid_id_w, 1);
        check("w_pc_id", pc_id_w, 64'h1_0000_0000);
        check("w_rs1_trunc", rs1_id_w, 4'd1);
        check("w_rs1_data", rs1_data_w, 64'hCAFE_0000_0000_0001);
        check("w_rd_id", rd_id_w, 4'd2);
        rf_we_w = 0; dbg_addr_w = 1;
        instr_w = I_ADDI_M1; pc_w = 64'h40;
        tick();
        check("w_imm_sext64", imm_id_w, 64'hFFFF_FFFF_FFFF_FFFF);
        check("w_rs2_trunc", rs2_id_w, 4'd15);
        check("w_func_id", func_id_w, 4'h8);
        check("w_dbg_x1", dbg_data_w, 64'hCAFE_0000_0000_0001);
        valid_w = 0;

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
